// File: rtl/scc_isa_pkg.sv
// Shared ISA constants for fetch and decode: instruction width, halt encoding,
// opcode field layout and the fetch-unit state encoding.
package scc_isa_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  localparam logic [OPC_W-1:0] OPC_ALU    = 6'h00;
  localparam logic [OPC_W-1:0] OPC_ALUI   = 6'h01;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 6'h08;
  localparam logic [OPC_W-1:0] OPC_STORE  = 6'h09;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 6'h10;
  localparam logic [OPC_W-1:0] OPC_JUMP   = 6'h11;
  localparam logic [OPC_W-1:0] OPC_SYS    = 6'h3F;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_e;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry in-order buffer of fetched words {pc, instr, epoch}. Entry 0 is
// always the head, so the head fields keep their last value once the queue drains.
module fetch_queue #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [DATA_W-1:0] push_instr,
  input  logic              push_epoch,
  output logic [ADDR_W-1:0] head_pc,
  output logic [DATA_W-1:0] head_instr,
  output logic              head_epoch,
  output logic              full,
  output logic              empty,
  output logic [1:0]        count
);

  localparam int E_W = ADDR_W + DATA_W + 1;

  logic [E_W-1:0] r_ent0;
  logic [E_W-1:0] r_ent1;
  logic [1:0]     r_count;
  logic [E_W-1:0] w_new;

  assign w_new = {push_pc, push_instr, push_epoch};
  assign {head_pc, head_instr, head_epoch} = r_ent0;
  assign full  = (r_count == 2'd2);
  assign empty = (r_count == 2'd0);
  assign count = r_count;

  // Flush only clears occupancy; entry data stays so the head output holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_ent0  <= '0;
      r_ent1  <= '0;
    end else if (flush) begin
      r_count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b11: begin
          if (r_count == 2'd2) begin
            r_ent0 <= r_ent1;
            r_ent1 <= w_new;
          end else begin
            r_ent0 <= w_new;
          end
        end
        2'b10: begin
          if (r_count == 2'd0) r_ent0 <= w_new;
          else                 r_ent1 <= w_new;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          if (r_count == 2'd2) r_ent0 <= r_ent1;
          r_count <= r_count - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, reads a synchronous instruction memory and
// feeds decode one word per cycle with stall, redirect and halt-on-HALT_WORD.
module instr_fetch
  import scc_isa_pkg::*;
#(
  parameter int                                   ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]                    RESET_PC  = '0,
  parameter logic [scc_isa_pkg::INSTR_W-1:0]      HALT_WORD = scc_isa_pkg::HALT_WORD
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  output logic                              imem_req,
  output logic [ADDR_W-1:0]                 imem_addr,
  input  logic [scc_isa_pkg::INSTR_W-1:0]   imem_rdata,
  input  logic                              stall,
  input  logic                              redirect,
  input  logic [ADDR_W-1:0]                 redirect_pc,
  output logic [scc_isa_pkg::INSTR_W-1:0]   instruction,
  output logic                              instr_valid,
  output logic [ADDR_W-1:0]                 instr_pc,
  output logic                              halted
);

  fetch_state_e        r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_epoch;
  logic                r_inflight;
  logic [ADDR_W-1:0]   r_req_pc;
  logic                r_req_epoch;

  logic                w_running;
  logic [1:0]          w_count;
  logic                w_full;
  logic                w_empty;
  logic [ADDR_W-1:0]   w_head_pc;
  logic [INSTR_W-1:0]  w_head_instr;
  logic                w_head_epoch;
  logic                w_head_live;
  logic                w_head_halt;
  logic                w_halt_hit;
  logic                w_redir;
  logic                w_valid;
  logic                w_pop;
  logic                w_push;
  logic                w_flush;
  logic [2:0]          w_used;
  logic                w_issue;

  assign w_running    = (r_state == FS_RUN);
  assign w_head_live  = !w_empty && (w_head_epoch == r_epoch);
  assign w_head_halt  = w_head_live && (w_head_instr == HALT_WORD);
  assign w_redir      = w_running && redirect;
  assign w_halt_hit   = w_running && w_head_halt && !redirect;
  assign w_valid      = w_running && w_head_live && !w_head_halt;
  assign w_pop        = w_valid && !stall && !redirect;
  assign w_flush      = w_redir || w_halt_hit;
  assign w_push       = r_inflight && (r_req_epoch == r_epoch) && w_running &&
                        !redirect && !w_halt_hit;

  // Slots claimed after this edge: queued words plus the pending response,
  // less the word decode takes now. Counting the pop keeps 1 word/cycle.
  assign w_used  = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = w_running && !redirect && !w_halt_hit && (w_used < 3'd2);

  assign imem_req    = w_issue;
  assign imem_addr   = r_pc;
  assign instruction = w_head_instr;
  assign instr_pc    = w_head_pc;
  assign instr_valid = w_valid;
  assign halted      = (r_state == FS_HALT);

  fetch_queue #(
    .ADDR_W (ADDR_W),
    .DATA_W (INSTR_W)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (w_push),
    .pop        (w_pop),
    .flush      (w_flush),
    .push_pc    (r_req_pc),
    .push_instr (imem_rdata),
    .push_epoch (r_req_epoch),
    .head_pc    (w_head_pc),
    .head_instr (w_head_instr),
    .head_epoch (w_head_epoch),
    .full       (w_full),
    .empty      (w_empty),
    .count      (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FS_IDLE;
      r_pc        <= RESET_PC;
      r_epoch     <= 1'b0;
      r_inflight  <= 1'b0;
      r_req_pc    <= '0;
      r_req_epoch <= 1'b0;
    end else begin
      case (r_state)
        FS_IDLE: if (start)      r_state <= FS_RUN;
        FS_RUN:  if (w_halt_hit) r_state <= FS_HALT;
        default: ;
      endcase
      // A redirect retires the old stream: any response tagged with the old epoch is dropped.
      if (w_redir) begin
        r_pc    <= redirect_pc;
        r_epoch <= ~r_epoch;
      end else if (w_issue) begin
        r_pc        <= r_pc + 1'b1;
        r_req_pc    <= r_pc;
        r_req_epoch <= r_epoch;
      end
      r_inflight <= w_issue;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && w_full && !w_pop));

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: program-order reference model plus directed and random scenarios.
module tb_instr_fetch;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, stall, redirect;
  logic [7:0]  redirect_pc;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [7:0]  instr_pc;
  logic        halted;

  logic        start_w;
  logic        req_w;
  logic [7:0]  addr_w;
  logic [31:0] rdata_w = '0;
  logic [31:0] instr_w;
  logic        valid_w;
  logic [7:0]  pc_w;
  logic        halted_w;

  logic [31:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  instr_fetch #(.ADDR_W(8), .RESET_PC(8'h00)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instruction(instruction), .instr_valid(instr_valid), .instr_pc(instr_pc), .halted(halted)
  );

  instr_fetch #(.ADDR_W(8), .RESET_PC(8'hFE)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .start(start_w), .imem_req(req_w), .imem_addr(addr_w),
    .imem_rdata(rdata_w), .stall(1'b0), .redirect(1'b0), .redirect_pc(8'h00),
    .instruction(instr_w), .instr_valid(valid_w), .instr_pc(pc_w), .halted(halted_w)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (imem_req) imem_rdata <= mem[imem_addr];
    if (req_w)    rdata_w    <= mem[addr_w];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: the decoder must see mem[] in program order from the start PC,
  // restarting at redirect_pc, two edges after start/redirect, stopping at a HALT word.
  int          m_state = 0;   // 0 idle, 1 run, 2 halted
  logic [7:0]  m_pc = 8'h00;
  int          m_age = 0;     // edges since start / last redirect
  int          start_cyc = 0;
  logic        m_head_halt;
  logic [7:0]  got_pc  [$];
  logic [31:0] got_ins [$];
  int          got_cyc [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", {24'd0, imem_addr}, 32'd0);
      chk("rst_instr", instruction, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_pc", {24'd0, instr_pc}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      m_state = 0;
      m_pc    = 8'h00;
      m_age   = 0;
    end else begin
      case (m_state)
        0: begin
          chk("idle_req", {31'd0, imem_req}, 32'd0);
          chk("idle_valid", {31'd0, instr_valid}, 32'd0);
          chk("idle_halted", {31'd0, halted}, 32'd0);
          chk("idle_addr", {24'd0, imem_addr}, {24'd0, m_pc});
          if (start) begin
            m_state   = 1;
            m_age     = 0;
            start_cyc = cyc + 1;
          end
        end
        1: begin
          m_head_halt = (m_age >= 2) && (mem[m_pc] == HALT);
          chk("run_halted", {31'd0, halted}, 32'd0);
          if (m_age < 2) chk("latency_valid", {31'd0, instr_valid}, 32'd0);
          else if (m_head_halt) chk("halt_hidden", {31'd0, instr_valid}, 32'd0);
          else begin
            chk("stream_valid", {31'd0, instr_valid}, 32'd1);
            if (instr_valid) begin
              chk("order_pc", {24'd0, instr_pc}, {24'd0, m_pc});
              chk("order_instr", instruction, mem[m_pc]);
            end
          end
          if (redirect) begin
            m_pc  = redirect_pc;
            m_age = 0;
          end else if (m_head_halt) begin
            m_state = 2;
          end else begin
            if (m_age >= 2 && !stall) begin
              if (instr_valid) begin
                got_pc.push_back(instr_pc);
                got_ins.push_back(instruction);
                got_cyc.push_back(cyc);
              end
              m_pc = m_pc + 8'd1;
            end
            if (m_age < 3) m_age = m_age + 1;
          end
        end
        default: begin
          chk("halt_halted", {31'd0, halted}, 32'd1);
          chk("halt_req", {31'd0, imem_req}, 32'd0);
          chk("halt_valid", {31'd0, instr_valid}, 32'd0);
        end
      endcase
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | i;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; redirect = 1'b0;
    redirect_pc = 8'h00; start_w = 1'b0;
    repeat (2) tick;
    got_pc.delete(); got_ins.delete(); got_cyc.delete();
    rst_n = 1'b1;
    tick;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_pc(input logic [7:0] pc, input string nm);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick;
      if (instr_valid && instr_pc == pc) found = 1'b1;
    end
    chk(nm, {31'd0, found}, 32'd1);
  endtask

  logic [31:0] exp_stream [4];
  logic [7:0]  wpc [$];
  logic [31:0] wins [$];
  logic        saw3;

  initial begin
    exp_stream[0] = 32'h0000_FFFF; exp_stream[1] = 32'h0200_EEEE;
    exp_stream[2] = 32'h0640_0000; exp_stream[3] = 32'h0480_0005;
    fill_mem;
    do_reset;

    // Reset / idle
    for (int i = 0; i < 10; i++) begin
      chk("idle_req_lit", {31'd0, imem_req}, 32'd0);
      chk("idle_valid_lit", {31'd0, instr_valid}, 32'd0);
      chk("idle_halted_lit", {31'd0, halted}, 32'd0);
      chk("idle_addr_lit", {24'd0, imem_addr}, 32'd0);
      tick;
    end

    // Stream of four words
    for (int i = 0; i < 4; i++) mem[i] = exp_stream[i];
    pulse_start;
    repeat (8) tick;
    chk("stream_count", {31'd0, got_pc.size() >= 4}, 32'd1);
    if (got_pc.size() >= 4) begin
      chk("stream_first_cycle", got_cyc[0], start_cyc + 2);
      for (int i = 0; i < 4; i++) begin
        chk("stream_pc", {24'd0, got_pc[i]}, i);
        chk("stream_word", got_ins[i], exp_stream[i]);
        chk("stream_cycle", got_cyc[i], got_cyc[0] + i);
      end
    end

    // Stall with 0200_EEEE at head
    do_reset;
    pulse_start;
    wait_pc(8'h01, "stall_reach");
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("stall_pc", {24'd0, instr_pc}, 32'd1);
      chk("stall_word", instruction, 32'h0200_EEEE);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      if (k >= 2) chk("stall_req", {31'd0, imem_req}, 32'd0);
      tick;
    end
    stall = 1'b0;
    repeat (6) tick;
    chk("stall_count", {31'd0, got_pc.size() >= 6}, 32'd1);
    if (got_pc.size() >= 6) begin
      for (int i = 0; i < 6; i++) chk("stall_seq_pc", {24'd0, got_pc[i]}, i);
      chk("stall_seq_w1", got_ins[1], 32'h0200_EEEE);
      chk("stall_seq_w2", got_ins[2], 32'h0640_0000);
      chk("stall_seq_w4", got_ins[4], 32'h1000_0004);
    end

    // Redirect while instr_pc=2 is presented
    do_reset;
    mem[8'h40] = 32'h0A0B_0C0D;
    pulse_start;
    wait_pc(8'h02, "redir_reach");
    redirect = 1'b1; redirect_pc = 8'h40;
    tick;
    redirect = 1'b0;
    chk("redir_gap0", {31'd0, instr_valid}, 32'd0);
    tick;
    chk("redir_gap1", {31'd0, instr_valid}, 32'd0);
    tick;
    chk("redir_valid", {31'd0, instr_valid}, 32'd1);
    chk("redir_pc", {24'd0, instr_pc}, 32'h40);
    chk("redir_word", instruction, 32'h0A0B_0C0D);
    repeat (4) tick;
    saw3 = 1'b0;
    foreach (got_pc[i]) if (got_pc[i] == 8'h03) saw3 = 1'b1;
    chk("redir_no_pc3", {31'd0, saw3}, 32'd0);
    chk("redir_count", {31'd0, got_pc.size() >= 4}, 32'd1);
    if (got_pc.size() >= 4) begin
      chk("redir_seq2", {24'd0, got_pc[2]}, 32'h40);
      chk("redir_seq3", {24'd0, got_pc[3]}, 32'h41);
    end

    // Halt on HALT_WORD at pc 2
    do_reset;
    mem[2] = HALT;
    pulse_start;
    repeat (12) tick;
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_count", got_pc.size(), 32'd2);
    if (got_pc.size() == 2) begin
      chk("halt_w0", got_ins[0], 32'h0000_FFFF);
      chk("halt_w1", got_ins[1], 32'h0200_EEEE);
    end
    redirect = 1'b1; redirect_pc = 8'h10; start = 1'b1;
    tick;
    redirect = 1'b0; start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("halt_req_lit", {31'd0, imem_req}, 32'd0);
      chk("halt_stays", {31'd0, halted}, 32'd1);
      tick;
    end

    // PC wrap with RESET_PC=0xFE
    fill_mem;
    do_reset;
    chk("wrap_rst_addr", {24'd0, addr_w}, 32'hFE);
    start_w = 1'b1;
    tick;
    start_w = 1'b0;
    wpc.delete(); wins.delete();
    for (int i = 0; i < 8; i++) begin
      tick;
      if (valid_w) begin
        wpc.push_back(pc_w);
        wins.push_back(instr_w);
      end
    end
    chk("wrap_count", {31'd0, wpc.size() >= 3}, 32'd1);
    if (wpc.size() >= 3) begin
      chk("wrap_pc0", {24'd0, wpc[0]}, 32'hFE);
      chk("wrap_pc1", {24'd0, wpc[1]}, 32'hFF);
      chk("wrap_pc2", {24'd0, wpc[2]}, 32'h00);
      chk("wrap_w0", wins[0], 32'h1000_00FE);
      chk("wrap_w2", wins[2], 32'h1000_0000);
    end

    // Asynchronous reset mid-stream
    do_reset;
    pulse_start;
    repeat (5) tick;
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", {31'd0, imem_req}, 32'd0);
    chk("async_addr", {24'd0, imem_addr}, 32'd0);
    chk("async_instr", instruction, 32'd0);
    chk("async_valid", {31'd0, instr_valid}, 32'd0);
    chk("async_pc", {24'd0, instr_pc}, 32'd0);
    chk("async_halted", {31'd0, halted}, 32'd0);
    chk("async_w_valid", {31'd0, valid_w}, 32'd0);
    @(posedge clk); #1;
    got_pc.delete(); got_ins.delete(); got_cyc.delete();
    rst_n = 1'b1;
    tick;
    pulse_start;
    repeat (6) tick;
    chk("async_restart", {31'd0, got_pc.size() >= 1}, 32'd1);
    if (got_pc.size() >= 1) chk("async_restart_pc", {24'd0, got_pc[0]}, 32'd0);

    // Randomized traffic against the model
    for (int r = 0; r < 6; r++) begin
      do_reset;
      for (int i = 0; i < 256; i++) begin
        mem[i] = $urandom & 32'h7FFF_FFFF;
        if ($urandom_range(0, 49) == 0) mem[i] = HALT;
      end
      pulse_start;
      for (int c = 0; c < 400; c++) begin
        stall       = ($urandom_range(0, 9) < 3);
        redirect    = ($urandom_range(0, 24) == 0);
        redirect_pc = 8'($urandom);
        start       = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 199) == 0) begin
          rst_n = 1'b0; start = 1'b0;
          tick; tick;
          rst_n = 1'b1;
        end
        tick;
      end
      start = 1'b0; stall = 1'b0; redirect = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
